// File: rtl/serial_word_framer_if.sv
// serial_word_framer_if: parallel load handshake plus the serial stream it produces
interface serial_word_framer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             ser_i;
  logic             ser_start;
  logic             ser_last;
  logic             ser_valid;
  modport master (
    output load_data, load_valid,
    input  load_ready, ser_i, ser_start, ser_last, ser_valid
  );
  modport slave (
    input  load_data, load_valid,
    output load_ready, ser_i, ser_start, ser_last, ser_valid
  );
endinterface

// File: rtl/serial_word_framer.sv
// serial_word_framer: LSB-first word serialiser with one-entry hold register,
// first/last bit strobes and an optional idle gap between words.
module serial_word_framer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input logic t_clk,
  input logic r,
  serial_word_framer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, hold_q, hold_d, word;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             ser_i_q, ser_i_d, ser_start_q, ser_start_d;
  logic             ser_last_q, ser_last_d, ser_valid_q, ser_valid_d;
  logic             accept, end_word, gap_end, next_word;
  always_comb begin
    accept    = bus.load_valid && !hold_full_q;
    end_word  = state_q == ST_SHIFT && bit_cnt_q == CW'(WIDTH - 1);
    gap_end   = state_q == ST_GAP && gap_cnt_q == 4'd1;
    next_word = (state_q != ST_SHIFT && state_q != ST_GAP) || gap_end || (end_word && GAP == 0);
    word      = hold_full_q ? hold_q : bus.load_data;
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_i_d     = 1'b0;
    ser_start_d = 1'b0;
    ser_last_d  = 1'b0;
    ser_valid_d = 1'b0;
    if (state_q == ST_SHIFT && !end_word) begin
      ser_i_d     = shift_q[0];
      ser_last_d  = bit_cnt_q == CW'(WIDTH - 2);
      ser_valid_d = 1'b1;
      shift_d     = shift_q >> 1;
      bit_cnt_d   = bit_cnt_q + 1'b1;
    end else if (end_word && GAP != 0) begin
      state_d   = ST_GAP;
      gap_cnt_d = 4'(GAP);
    end else if (state_q == ST_GAP && !gap_end) begin
      gap_cnt_d = gap_cnt_q - 4'd1;
    end else if (hold_full_q || accept) begin
      // a held word always wins; a fresh accept cannot coincide with it
      state_d     = ST_SHIFT;
      shift_d     = word >> 1;
      ser_i_d     = word[0];
      ser_start_d = 1'b1;
      ser_valid_d = 1'b1;
      bit_cnt_d   = '0;
      hold_full_d = 1'b0;
    end else begin
      state_d = ST_IDLE;
    end
    if (accept && !next_word) begin
      hold_d      = bus.load_data;
      hold_full_d = 1'b1;
    end
  end
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_i_q     <= 1'b0;
      ser_start_q <= 1'b0;
      ser_last_q  <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_i_q     <= ser_i_d;
      ser_start_q <= ser_start_d;
      ser_last_q  <= ser_last_d;
      ser_valid_q <= ser_valid_d;
    end
  end
  assign bus.load_ready = ~hold_full_q;
  assign bus.ser_i      = ser_i_q;
  assign bus.ser_start  = ser_start_q;
  assign bus.ser_last   = ser_last_q;
  assign bus.ser_valid  = ser_valid_q;
endmodule

// File: tb/tb_serial_word_framer.sv
// tb_serial_word_framer: directed scenarios on a GAP=0 and a GAP=2 framer
module tb_serial_word_framer;
  logic t_clk = 1'b0;
  logic r = 1'b0;
  int checks = 0;
  int fails = 0;
  serial_word_framer_if #(.WIDTH(8)) if0 ();
  serial_word_framer_if #(.WIDTH(8)) if2 ();
  serial_word_framer #(.WIDTH(8), .GAP(0)) dut0 (.t_clk(t_clk), .r(r), .bus(if0));
  serial_word_framer #(.WIDTH(8), .GAP(2)) dut2 (.t_clk(t_clk), .r(r), .bus(if2));
  always #5 t_clk = ~t_clk;

  task automatic test_reset;
    r = 1'b0;
    if0.load_valid = 1'b1; if0.load_data = 8'hAA;
    if2.load_valid = 1'b1; if2.load_data = 8'h55;
    repeat (3) @(posedge t_clk);
    @(negedge t_clk);
    checks++;
    if ({if0.ser_i, if0.ser_start, if0.ser_last, if0.ser_valid} !== 4'b0000) begin
      fails++; $display("FAIL reset_outputs got %b expected 0000", {if0.ser_i, if0.ser_start, if0.ser_last, if0.ser_valid});
    end
    checks++;
    if (if0.load_ready !== 1'b1) begin fails++; $display("FAIL reset_load_ready got %b expected 1", if0.load_ready); end
    checks++;
    if (if2.ser_valid !== 1'b0) begin fails++; $display("FAIL reset_gap_valid got %b expected 0", if2.ser_valid); end
    if0.load_valid = 1'b0; if2.load_valid = 1'b0;
    #2 r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge t_clk);
      checks++;
      if (if0.ser_valid !== 1'b0) begin fails++; $display("FAIL release_valid cyc %0d got %b expected 0", i, if0.ser_valid); end
      checks++;
      if (if0.load_ready !== 1'b1) begin fails++; $display("FAIL release_ready cyc %0d got %b expected 1", i, if0.load_ready); end
    end
  endtask

  task automatic test_single;
    logic [7:0] w = 8'h68;
    logic [7:0] inv = 8'h00;
    logic seen = 1'b0;
    logic o;
    @(posedge t_clk); #1 if0.load_valid = 1'b1; if0.load_data = w;
    @(posedge t_clk); #1 if0.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge t_clk);
      checks++;
      if ({if0.ser_valid, if0.ser_i, if0.ser_start, if0.ser_last} !== {1'b1, w[i], i == 0, i == 7}) begin
        fails++; $display("FAIL single bit %0d got v/i/s/l %b expected %b", i,
          {if0.ser_valid, if0.ser_i, if0.ser_start, if0.ser_last}, {1'b1, w[i], i == 0, i == 7});
      end
      if (if0.ser_start) seen = 1'b0;
      o = if0.ser_i ^ seen;
      seen = seen | if0.ser_i;
      inv[i] = o;
    end
    @(negedge t_clk);
    checks++;
    if (if0.ser_valid !== 1'b0) begin fails++; $display("FAIL single_end_valid got %b expected 0", if0.ser_valid); end
    checks++;
    if (inv !== 8'h98) begin fails++; $display("FAIL single_inverted got %h expected 98", inv); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s = 16'hFF01;
    @(posedge t_clk); #1 if0.load_valid = 1'b1; if0.load_data = 8'h01;
    @(posedge t_clk); #1 if0.load_data = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      @(negedge t_clk);
      checks++;
      if ({if0.ser_valid, if0.ser_i, if0.ser_start} !== {1'b1, s[k], k == 0 || k == 8}) begin
        fails++; $display("FAIL b2b cyc %0d got v/i/s %b expected %b", k,
          {if0.ser_valid, if0.ser_i, if0.ser_start}, {1'b1, s[k], k == 0 || k == 8});
      end
      checks++;
      if (if0.load_ready !== !(k >= 1 && k <= 7)) begin
        fails++; $display("FAIL b2b_ready cyc %0d got %b expected %b", k, if0.load_ready, !(k >= 1 && k <= 7));
      end
      if (k == 0) begin @(posedge t_clk); #1 if0.load_valid = 1'b0; end
    end
    @(negedge t_clk);
    checks++;
    if (if0.ser_valid !== 1'b0) begin fails++; $display("FAIL b2b_end_valid got %b expected 0", if0.ser_valid); end
  endtask

  task automatic test_gap;
    logic [17:0] s = 18'b11110000_00_00001111;
    logic exp_v, exp_st, exp_l;
    @(posedge t_clk); #1 if2.load_valid = 1'b1; if2.load_data = 8'h0F;
    @(posedge t_clk); #1 if2.load_data = 8'hF0;
    for (int k = 0; k < 19; k++) begin
      @(negedge t_clk);
      exp_v = k < 8 || (k >= 10 && k < 18);
      exp_st = k == 0 || k == 10;
      exp_l = k == 7 || k == 17;
      checks++;
      if ({if2.ser_valid, if2.ser_i, if2.ser_start, if2.ser_last} !== {exp_v, k < 18 ? s[k] : 1'b0, exp_st, exp_l}) begin
        fails++; $display("FAIL gap cyc %0d got v/i/s/l %b expected %b", k,
          {if2.ser_valid, if2.ser_i, if2.ser_start, if2.ser_last}, {exp_v, k < 18 ? s[k] : 1'b0, exp_st, exp_l});
      end
      if (k == 0) begin @(posedge t_clk); #1 if2.load_valid = 1'b0; end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] words [3] = '{8'hAA, 8'h55, 8'h33};
    int acc_at [3] = '{-1, -1, -1};
    int n = 0;
    int nv = 0;
    int bp = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] rx [$];
    logic acc;
    @(posedge t_clk); #1 if0.load_valid = 1'b1; if0.load_data = words[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge t_clk);
      if (if0.ser_valid) begin
        nv++;
        if (if0.ser_start) bp = 0;
        cur[bp[2:0]] = if0.ser_i;
        bp++;
        if (if0.ser_last) rx.push_back(cur);
      end
      acc = if0.load_valid && if0.load_ready;
      @(posedge t_clk);
      if (acc) begin
        if (n < 3) acc_at[n] = c;
        n++;
      end
      #1;
      if (n < 3) if0.load_data = words[n];
      else if0.load_valid = 1'b0;
    end
    checks++;
    if (n !== 3) begin fails++; $display("FAIL bp_accepts got %0d expected 3", n); end
    checks++;
    if (acc_at[0] !== 0 || acc_at[1] !== 1 || acc_at[2] !== 9) begin
      fails++; $display("FAIL bp_accept_cycles got %0d,%0d,%0d expected 0,1,9", acc_at[0], acc_at[1], acc_at[2]);
    end
    checks++;
    if (nv !== 24) begin fails++; $display("FAIL bp_valid_cycles got %0d expected 24", nv); end
    checks++;
    if (rx.size() !== 3) begin fails++; $display("FAIL bp_rx_count got %0d expected 3", rx.size()); end
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== words[i]) begin fails++; $display("FAIL bp_rx_word %0d got %h expected %h", i, rx[i], words[i]); end
    end
  endtask

  task automatic test_reset_midword;
    logic [7:0] w = 8'h81;
    int seen = 0;
    @(posedge t_clk); #1 if0.load_valid = 1'b1; if0.load_data = 8'hC3;
    @(posedge t_clk); #1 if0.load_data = 8'h3C;
    @(posedge t_clk); #1 if0.load_valid = 1'b0;
    @(posedge t_clk);
    @(posedge t_clk); #2;
    checks++;
    if ({if0.ser_valid, if0.ser_i, if0.load_ready} !== 3'b100) begin
      fails++; $display("FAIL mid_pre_reset got v/i/rdy %b expected 100", {if0.ser_valid, if0.ser_i, if0.load_ready});
    end
    r = 1'b0;
    #1;
    checks++;
    if ({if0.ser_valid, if0.ser_i, if0.ser_start, if0.ser_last} !== 4'b0000) begin
      fails++; $display("FAIL mid_async_drop got %b expected 0000", {if0.ser_valid, if0.ser_i, if0.ser_start, if0.ser_last});
    end
    checks++;
    if (if0.load_ready !== 1'b1) begin fails++; $display("FAIL mid_hold_cleared got %b expected 1", if0.load_ready); end
    #1 r = 1'b1;
    repeat (12) begin
      @(negedge t_clk);
      if (if0.ser_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL mid_no_replay got %0d valid cycles expected 0", seen); end
    @(posedge t_clk); #1 if0.load_valid = 1'b1; if0.load_data = w;
    @(posedge t_clk); #1 if0.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge t_clk);
      checks++;
      if ({if0.ser_valid, if0.ser_i, if0.ser_start, if0.ser_last} !== {1'b1, w[i], i == 0, i == 7}) begin
        fails++; $display("FAIL mid_fresh bit %0d got %b expected %b", i,
          {if0.ser_valid, if0.ser_i, if0.ser_start, if0.ser_last}, {1'b1, w[i], i == 0, i == 7});
      end
    end
  endtask

  initial begin
    if0.load_valid = 1'b0; if0.load_data = 8'h00;
    if2.load_valid = 1'b0; if2.load_data = 8'h00;
    test_reset;
    test_single;
    test_back_to_back;
    test_gap;
    test_backpressure;
    test_reset_midword;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/serial_word_framer.md
Name: serial_word_framer

Overview:
Upstream feeder for the bit-serial two's-complement inverter. Accepts parallel words over a valid/ready handshake and serialises them LSB-first onto a one-bit stream. Emits a first-bit strobe that drives the inverter's restart input, so each word is complemented independently. A one-entry holding register allows gap-free back-to-back words.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
GAP, 0, idle cycles (ser_valid=0) inserted between consecutive words; legal range 0..15.

Ports:
t_clk  input  1  clock; all state updates on the rising edge.
r  input  1  reset, asynchronous, active-low.
load_data  input  WIDTH  parallel word to serialise.
load_valid  input  1  load_data is valid this cycle.
load_ready  output  1  framer can accept a word this cycle.
ser_i  output  1  serial data bit, LSB first; feeds the inverter data input.
ser_start  output  1  high on bit 0 of each word; feeds the inverter restart input.
ser_last  output  1  high on bit WIDTH-1 of each word.
ser_valid  output  1  ser_i carries a word bit this cycle.

Behaviour:
- Reset (r=0, asynchronous): ser_i=0, ser_start=0, ser_last=0, ser_valid=0, hold register empty, shifter idle, bit counter=0, gap counter=0. load_ready=1 while in reset.
- Reset mid-word: the in-flight word and any held word are discarded immediately. There is no partial output after release. The first word after release starts with ser_start=1.
- Outputs ser_i, ser_start, ser_last and ser_valid are registered. load_ready is ~hold_full, a flop with no combinational path from load_valid.
- Accept occurs on a rising edge with load_valid=1 and load_ready=1.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - On accept, the word loads directly into the shifter; the hold register stays empty.
  - Next state SHIFT, with bit 0 on ser_i in the cycle after the accepting edge.
  - Latency is 1 cycle.
- SHIFT:
  - One bit per cycle; ser_i = shifter[0], and the shifter shifts right each edge.
  - ser_start=1 when bit_cnt=0; ser_last=1 when bit_cnt=WIDTH-1.
  - ser_valid=1 throughout.
  - An accept during SHIFT writes the hold register, and load_ready falls next cycle.
- At the edge ending the last bit:
  - If GAP>0, go to GAP with gap_cnt=GAP.
  - Else if the hold register is full, move the hold word to the shifter and remain in SHIFT. The next word's bit 0 follows with no bubble, and the hold register is freed.
  - Else if an accept happens at this same edge, load that word directly and remain in SHIFT with no bubble.
  - Otherwise go to IDLE.
- GAP:
  - ser_valid=0, ser_start=0, ser_last=0 and ser_i=0 for exactly GAP cycles.
  - Accepts into the hold register are permitted.
  - On expiry, go to SHIFT if a word is held or accepted at that edge, else IDLE.
- Throughput: with GAP=0 and continuous load_valid, ser_valid stays high indefinitely.
- No combinational path from load_data to ser_i.
- Simultaneous hold-drain and new load_valid at the same edge: the new word is not accepted, because load_ready was 0 that cycle. It is accepted on the following edge.
- Between words ser_i is driven 0.

Test Plan:
1. Reset: hold r=0 with load_valid=1 and toggling t_clk -> all serial outputs 0, no accept. Release r -> load_ready=1, ser_valid=0.
2. Single word, WIDTH=8, GAP=0, load 0x68 -> starting 1 cycle after accept, ser_i = 0,0,0,1,0,1,1,0. ser_start only on the first of these bits, ser_last only on the eighth. The downstream inverter output decodes to 0x98.
3. Back-to-back 0x01 then 0xFF, GAP=0 -> 16 consecutive ser_valid cycles, ser_start at cycles 0 and 8. load_ready=0 from the cycle after the second accept until the edge where 0xFF moves to the shifter.
4. GAP=2, two words 0x0F and 0xF0 -> ser_valid pattern is 8 high, 2 low, 8 high. ser_i=0 and ser_start=0 in the gap cycles.
5. Backpressure with load_valid held high across three words 0xAA, 0x55, 0x33 -> exactly one accept per word. 0x33 stays presented while load_ready=0 and is accepted the edge after 0x55 leaves the hold register. Serial order is 0xAA, 0x55, 0x33 with no loss or duplication.
6. Reset mid-word: assert r=0 asynchronously (between edges) while bit 3 of 0xC3 is on ser_i, with 0x3C held -> ser_valid and ser_i drop without waiting for an edge. After release, neither word reappears. A fresh 0x81 serialises with ser_start on its first bit.
